// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver.
// Channel encodings follow the wclk level on the link.
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 24;
  localparam int BITCNT_W_DEF = 6;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic {
    SYNC,
    RUN
  } state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Link synchronizers and bclk rise detector.
// wclk/sdata are delayed so they line up with the rise strobe.
module i2s_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bclk_i,
  input  logic wclk_i,
  input  logic sdata_i,
  output logic rise_o,
  output logic wclk_o,
  output logic sdata_o
);

  logic [1:0] bclk_sq;
  logic [1:0] wclk_sq;
  logic [1:0] sdata_sq;
  logic       bclk_prev_q;
  logic       rise_q;
  logic       wclk_q;
  logic       sdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclk_sq     <= '0;
      wclk_sq     <= '0;
      sdata_sq    <= '0;
      bclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      wclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
    end else begin
      bclk_sq     <= {bclk_sq[0], bclk_i};
      wclk_sq     <= {wclk_sq[0], wclk_i};
      sdata_sq    <= {sdata_sq[0], sdata_i};
      bclk_prev_q <= bclk_sq[1];
      rise_q      <= bclk_sq[1] & ~bclk_prev_q;
      wclk_q      <= wclk_sq[1];
      sdata_q     <= sdata_sq[1];
    end
  end

  assign rise_o  = rise_q;
  assign wclk_o  = wclk_q;
  assign sdata_o = sdata_q;

endmodule

// File: rtl/i2s_rx_core.sv
// I2S receiver: deserializes stereo words and hands
// out (left, right) pairs over valid/ready.
module i2s_rx_core
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int BITCNT_W = BITCNT_W_DEF
) (
  input  logic                adc_clk,
  input  logic                rst_n,
  input  logic                i2s_bclk,
  input  logic                i2s_wclk,
  input  logic                i2s_sdata,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output logic                frame_err
);

  localparam logic [BITCNT_W-1:0] SW = BITCNT_W'(SAMPLE_W);

  logic slot;
  logic wclk_s;
  logic sdata_s;

  i2s_sync_edge u_sync (
    .clk_i   (adc_clk),
    .rst_ni  (rst_n),
    .bclk_i  (i2s_bclk),
    .wclk_i  (i2s_wclk),
    .sdata_i (i2s_sdata),
    .rise_o  (slot),
    .wclk_o  (wclk_s),
    .sdata_o (sdata_s)
  );

  state_e              state_q, state_d;
  logic                wclk_d_q, wclk_d_d;
  logic                chan_q, chan_d;
  logic [BITCNT_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic                have_left_q, have_left_d;
  logic [SAMPLE_W-1:0] out_left_q, out_left_d;
  logic [SAMPLE_W-1:0] out_right_q, out_right_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic                ferr_q, ferr_d;

  logic                chg;
  logic                commit;
  logic                short_w;
  logic                pair_done;
  logic [SAMPLE_W-1:0] commit_val;
  logic [SAMPLE_W-1:0] shift_n;
  logic [BITCNT_W-1:0] cnt_n;

  assign chg = wclk_s != wclk_d_q;

  // Word datapath: shift, commit (full or short), then word start.
  always_comb begin
    state_d    = state_q;
    wclk_d_d   = wclk_d_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    commit     = 1'b0;
    short_w    = 1'b0;
    commit_val = '0;
    shift_n    = shift_q;
    cnt_n      = cnt_q;
    if (slot) begin
      wclk_d_d = wclk_s;
      unique case (state_q)
        SYNC: begin
          if (chg) begin
            state_d = RUN;
            chan_d  = wclk_s;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        RUN: begin
          if (cnt_q < SW) begin
            shift_n = {shift_q[SAMPLE_W-2:0], sdata_s};
            cnt_n   = cnt_q + BITCNT_W'(1);
          end
          if (cnt_q < SW && cnt_n == SW) begin
            commit     = 1'b1;
            commit_val = shift_n;
          end else if (chg && cnt_n < SW) begin
            commit     = 1'b1;
            short_w    = 1'b1;
            commit_val = shift_n << (SW - cnt_n);
          end
          shift_d = shift_n;
          cnt_d   = cnt_n;
          if (chg) begin
            cnt_d   = '0;
            shift_d = '0;
            chan_d  = wclk_s;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  assign pair_done = commit && (chan_q == CH_RIGHT) && have_left_q;

  always_comb begin
    left_d      = left_q;
    have_left_d = have_left_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    ferr_d      = short_w;
    if (commit) begin
      have_left_d = chan_q == CH_LEFT;
      if (chan_q == CH_LEFT) left_d = commit_val;
    end
    if (pair_done) begin
      if (!out_valid_q || out_ready) begin
        out_left_d  = left_q;
        out_right_d = commit_val;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      wclk_d_q    <= 1'b0;
      chan_q      <= CH_LEFT;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      have_left_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wclk_d_q    <= wclk_d_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      have_left_q <= have_left_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_i2s_rx_core.sv
// Scoreboard bench for i2s_rx_core: directed I2S frames,
// expected pairs queued at send time, checked by a monitor.
module tb_i2s_rx_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk = 1'b0;
  logic        wclk = 1'b0;
  logic        sdata = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] out_left;
  logic [23:0] out_right;
  logic        out_valid;
  logic        overrun;
  logic        frame_err;

  always #5 clk = ~clk;

  i2s_rx_core dut (
    .adc_clk   (clk),
    .rst_n     (rst_n),
    .i2s_bclk  (bclk),
    .i2s_wclk  (wclk),
    .i2s_sdata (sdata),
    .out_left  (out_left),
    .out_right (out_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  pair_t q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    ovr_cnt = 0;
  int    ferr_cnt = 0;
  logic  prev_bit = 1'b0;
  logic  head_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses, checks hold stability, pops on transfer.
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [23:0] pl = '0;
  logic [23:0] prr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (pv && !pr && out_valid) begin
        chk("hold_left", 32'(out_left), 32'(pl));
        chk("hold_right", 32'(out_right), 32'(prr));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_pair", 32'(q.size()), 32'd1);
        end else begin
          pair_t e;
          e = q.pop_front();
          chk("pair_left", 32'(out_left), 32'(e.l));
          chk("pair_right", 32'(out_right), 32'(e.r));
        end
      end
    end
    pv  = out_valid;
    pr  = out_ready;
    pl  = out_left;
    prr = out_right;
  end

  function automatic logic bitof(input logic [23:0] d, input int dbits,
                                 input int j);
    if (j < dbits) return d[dbits-1-j];
    return 1'b0;
  endfunction

  task automatic slot(input logic w, input logic d);
    @(negedge clk);
    bclk = 1'b0;
    wclk = w;
    sdata = d;
    @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_half(input logic ch, input logic [23:0] d,
                           input int n, input int dbits, input bit pause);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && head_done) begin
        head_done = 1'b0;
        continue;
      end
      if (pause && i == 10) repeat (100) @(negedge clk);
      slot(ch, (i == 0) ? prev_bit : bitof(d, dbits, i - 1));
    end
    prev_bit = bitof(d, dbits, n - 1);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int n, input int dbits, input bit pause);
    send_half(1'b0, l, n, dbits, pause);
    send_half(1'b1, r, n, dbits, 1'b0);
  endtask

  // Closes the last right word by starting the next left half.
  task automatic flush();
    slot(1'b0, prev_bit);
    head_done = 1'b1;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    q.push_back(p);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  int f0, o0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_left", 32'(out_left), 32'd0);
    chk("rst_right", 32'(out_right), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: first frame after reset is discarded, second delivered
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(24'h123456, 24'hABCDEF, 24, 24, 1'b0);
    push(24'h123456, 24'hABCDEF);
    send_frame(24'h123456, 24'hABCDEF, 24, 24, 1'b0);
    flush();
    drain("t1_drain");
    chk("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("t1_ovr", 32'(ovr_cnt - o0), 32'd0);

    // 2: backpressure, first pair held, two overruns
    set_ready(1'b0);
    f0 = ferr_cnt; o0 = ovr_cnt;
    push(24'h800000, 24'h7FFFFF);
    for (int k = 0; k < 3; k++)
      send_frame(24'h800000, 24'h7FFFFF, 24, 24, 1'b0);
    flush();
    repeat (10) @(negedge clk);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_ovr", 32'(ovr_cnt - o0), 32'd2);
    set_ready(1'b1);
    drain("t2_drain");
    chk("t2_valid_clr", 32'(out_valid), 32'd0);

    // 3: 16-slot halves, left-aligned and frame errors
    f0 = ferr_cnt;
    push(24'hA5A500, 24'h5A5A00);
    send_frame(24'h00A5A5, 24'h005A5A, 16, 16, 1'b0);
    push(24'hA5A500, 24'h5A5A00);
    send_frame(24'h00A5A5, 24'h005A5A, 16, 16, 1'b0);
    flush();
    drain("t3_drain");
    chk("t3_ferr", 32'(ferr_cnt - f0), 32'd4);

    // 4: 32-slot halves, trailing slots ignored
    f0 = ferr_cnt;
    push(24'h13579B, 24'hFDB975);
    send_frame(24'h13579B, 24'hFDB975, 32, 24, 1'b0);
    flush();
    drain("t4_drain");
    chk("t4_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 5: reset mid left word
    for (int i = 1; i < 10; i++) slot(1'b0, i[0]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_left", 32'(out_left), 32'd0);
    chk("t5_right", 32'(out_right), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    head_done = 1'b0;
    prev_bit = 1'b0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(24'h0F0F0F, 24'hF0F0F0, 24, 24, 1'b0);
    push(24'h3C3C3C, 24'hC3C3C3);
    send_frame(24'h3C3C3C, 24'hC3C3C3, 24, 24, 1'b0);
    flush();
    drain("t5_drain");
    chk("t5_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 6: bclk stalls mid left word
    f0 = ferr_cnt;
    push(24'h6B1D2E, 24'h9C8F70);
    send_frame(24'h6B1D2E, 24'h9C8F70, 24, 24, 1'b1);
    flush();
    drain("t6_drain");
    chk("t6_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("total_ovr", 32'(ovr_cnt - o0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
